canvas_streamer: RTL
====================

# canvas_streamer

Downstream of the canvas editor. Converts the 28x28 canvas array into a serial pixel stream for the classifier's input loader. On a start request it rasterises the canvas row-major (Y outer, X inner), presents one 16-bit pixel per handshake with a last flag, counts non-zero ("inked") pixels, and pulses done with the count when the final pixel is accepted.

## Interface
Parameters:
- DIM, 28, canvas edge length in blocks
- PIX_W, 16, pixel width; matches the canvas cell width

Ports:
- frame_clk  in  1  clock
- Reset  in  1  asynchronous, active-high reset
- start  in  1  request a stream; accepted only in IDLE
- canvas  in  [PIX_W-1:0] x [DIM-1:0][DIM-1:0]  canvas cells, indexed [X][Y]
- busy  out  1  high in every state except IDLE
- out_data  out  PIX_W  current pixel value
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_last  out  1  high with the pixel at index DIM*DIM-1
- out_index  out  10  raster index, row*DIM+col, of out_data
- done  out  1  one-cycle pulse after the last pixel is accepted
- ink_count  out  10  number of non-zero pixels in the last completed stream

## Operation
- States: IDLE, STREAM, DONE.
- IDLE: if start=1, set col=0 and row=0, load pixel (0,0) into the output register, set out_valid=1, and go to STREAM. Clear the running ink counter.
- STREAM: on each handshake, add 1 to the ink counter if out_data!=0. If the accepted pixel is not the last one, advance col. When col reaches DIM-1, wrap col to 0 and increment row. Load the next pixel, canvas[col][row], into the output register and keep out_valid=1.
- STREAM: a handshake on the last pixel (row=col=DIM-1) drops out_valid, latches the final ink count (including that pixel) into ink_count, and goes to DONE.
- DONE: assert done for one cycle, then return to IDLE.
- While out_valid=1 && out_ready=0, out_data, out_index and out_last hold stable.
- start is ignored when not in IDLE. There is no queueing.
- ink_count holds its value until the next stream completes.
- Pixel values pass through unmodified. No saturation or scaling.
- Arithmetic: out_index = row*DIM+col, 10 bits, maximum 783. The ink counter is 10 bits and cannot overflow.

## Timing
- Reset values: state=IDLE, busy=0, out_valid=0, out_data=0, out_last=0, out_index=0, done=0, ink_count=0.
- start sampled high at edge t: out_valid=1 with pixel 0 visible after edge t. busy=1 from t.
- With out_ready held high: one pixel per cycle. The last handshake happens at edge t+783, done is high after edge t+784, and busy=0 after edge t+785.
- Reset asserted mid-stream: immediately returns to the reset values. A partial count is discarded and ink_count reads 0.
- The start edge and the Reset edge arriving together: Reset wins.

## Configuration
- CANVAS_STREAMER_SNAPSHOT_EN defined:
  - The whole canvas is copied into an internal register array at the edge where start is accepted.
  - All pixels are read from the copy, so edits made during streaming are invisible.
- Not defined:
  - No copy is made.
  - Each pixel is sampled live from canvas at the edge that loads it into the output register.
  - Editor updates that land mid-stream appear for pixels not yet loaded.

## Structure
- Shared package canvas_pkg holds:
  - CANVAS_DIM=28, CANVAS_PIXELS=784, CANVAS_PIX_W=16, CANVAS_IDX_W=10
  - typedef canvas_t (the unpacked [27:0][27:0] array of 16-bit cells)
  - the state enum stream_state_e
- One sub-module: canvas_raster_counter.
  - Holds col/row with wrap and increment enable, and outputs index and is_last.
  - The FSM, output register, ink counter and optional snapshot stay in canvas_streamer.

## Test plan
- Canvas all zero, out_ready=1, start pulse: 784 beats, indices 0..783 in order, out_last only on beat 783, done one cycle later, ink_count=0.
- canvas[3][5]=500 and canvas[27][27]=2048, rest zero:
  - beat 143 carries 500 and beat 783 carries 2048 with out_last=1
  - ink_count=2
- Same stream with out_ready toggling 1,0,0,1: data held stable while stalled, no beat lost or duplicated, done delayed accordingly.
- start pulsed again during STREAM: ignored, stream completes normally. start in IDLE after done starts a new stream.
- Reset asserted at beat 400: outputs return to reset values immediately. A following start restarts from index 0.
- Write canvas[0][27]=1000 after the stream has started (index 756 not yet reached):
  - SNAPSHOT_EN defined: beat 756 carries 0
  - not defined: beat 756 carries 1000

Source files
------------

// File: rtl/canvas_pkg.sv
// Shared canvas geometry, the canvas array type and the streamer state encoding.
package canvas_pkg;

    localparam int CANVAS_DIM    = 28;
    localparam int CANVAS_PIXELS = CANVAS_DIM * CANVAS_DIM;
    localparam int CANVAS_PIX_W  = 16;
    localparam int CANVAS_IDX_W  = 10;

    // Cells are indexed [X][Y], matching the canvas editor.
    typedef logic [CANVAS_PIX_W-1:0] canvas_t [CANVAS_DIM-1:0][CANVAS_DIM-1:0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } stream_state_e;

endpackage

// File: rtl/canvas_streamer_if.sv
// Pixel stream bus from canvas_streamer to the classifier input loader.
interface canvas_streamer_if
    import canvas_pkg::*;
#(
    parameter int PIX_W = CANVAS_PIX_W
) ();

    logic [PIX_W-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic [CANVAS_IDX_W-1:0] out_index;

    modport master (output out_data, out_valid, out_last, out_index, input out_ready);
    modport slave  (input out_data, out_valid, out_last, out_index, output out_ready);

endinterface

// File: rtl/canvas_raster_counter.sv
// Row-major (Y outer, X inner) raster position of the pixel held in the output register.
module canvas_raster_counter
    import canvas_pkg::*;
#(
    parameter int DIM = CANVAS_DIM,
    parameter int CW  = $clog2(DIM)
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic                    clear,
    input  logic                    advance,
    output logic [CW-1:0]           next_col,
    output logic [CW-1:0]           next_row,
    output logic [CANVAS_IDX_W-1:0] index,
    output logic                    is_last
);

    logic [CW-1:0] col;
    logic [CW-1:0] row;

    // NOTE: every output gets a default first, so no latch is inferred.
    always_comb begin
        next_col = col + CW'(1);
        next_row = row;
        if (col == CW'(DIM - 1)) begin
            next_col = '0;
            next_row = row + CW'(1);
        end
    end

    assign index   = CANVAS_IDX_W'(row) * CANVAS_IDX_W'(DIM) + CANVAS_IDX_W'(col);
    assign is_last = (col == CW'(DIM - 1)) && (row == CW'(DIM - 1));

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            col <= next_col;
            row <= next_row;
        end
    end

endmodule

// File: rtl/canvas_streamer.sv
// Streams the canvas row-major with a valid/ready handshake and counts inked pixels.
// Define CANVAS_STREAMER_SNAPSHOT_EN to freeze a copy of the canvas when a stream starts.
module canvas_streamer
    import canvas_pkg::*;
#(
    parameter int DIM   = CANVAS_DIM,
    parameter int PIX_W = CANVAS_PIX_W
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic [PIX_W-1:0]        canvas [DIM-1:0][DIM-1:0],
    canvas_streamer_if.master       pix,
    output logic                    busy,
    output logic                    done,
    output logic [CANVAS_IDX_W-1:0] ink_count
);

    localparam int CW = $clog2(DIM);

    stream_state_e           state;
    logic [CW-1:0]           next_col;
    logic [CW-1:0]           next_row;
    logic [CANVAS_IDX_W-1:0] index;
    logic [CANVAS_IDX_W-1:0] ink_run;
    logic [PIX_W-1:0]        next_pix;
    logic                    is_last;
    logic                    clear;
    logic                    accept;
    logic                    advance;
    logic                    inked;

    assign clear   = (state == ST_IDLE) && start;
    assign accept  = (state == ST_STREAM) && pix.out_valid && pix.out_ready;
    assign advance = accept && !is_last;
    assign inked   = (pix.out_data != '0);

    canvas_raster_counter #(.DIM(DIM), .CW(CW)) u_raster (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .clear     (clear),
        .advance   (advance),
        .next_col  (next_col),
        .next_row  (next_row),
        .index     (index),
        .is_last   (is_last)
    );

`ifdef CANVAS_STREAMER_SNAPSHOT_EN
    logic [PIX_W-1:0] snapshot [DIM-1:0][DIM-1:0];

    // NOTE: the snapshot array has no reset; it is always loaded before it is read.
    always_ff @(posedge frame_clk) begin
        if (clear) snapshot <= canvas;
    end

    assign next_pix = snapshot[next_col][next_row];
`else
    assign next_pix = canvas[next_col][next_row];
`endif

    assign busy          = (state != ST_IDLE);
    assign pix.out_index = index;
    assign pix.out_last  = pix.out_valid && is_last;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state         <= ST_IDLE;
            pix.out_data  <= '0;
            pix.out_valid <= 1'b0;
            done          <= 1'b0;
            ink_run       <= '0;
            ink_count     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Pixel (0,0) is taken live; the snapshot copies the same value this edge.
                        pix.out_data  <= canvas[0][0];
                        pix.out_valid <= 1'b1;
                        ink_run       <= '0;
                        state         <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        if (is_last) begin
                            pix.out_valid <= 1'b0;
                            ink_count     <= ink_run + CANVAS_IDX_W'(inked);
                            state         <= ST_DONE;
                        end else begin
                            pix.out_data <= next_pix;
                            ink_run      <= ink_run + CANVAS_IDX_W'(inked);
                        end
                    end
                end
                ST_DONE: begin
                    // First DONE cycle raises done, the second drops it and returns to IDLE.
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
